// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared opcodes, FSM state encoding and instruction field helpers for the mini CPU.
// Revision 1.0
`default_nettype none

package cpu_pkg;

  localparam int DEF_PC_WIDTH    = 4;
  localparam int DEF_DATA_WIDTH  = 4;
  localparam int DEF_INSTR_WIDTH = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_INC  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  function automatic logic [3:0] instr_opcode(input logic [DEF_INSTR_WIDTH-1:0] instr);
    return instr[7:4];
  endfunction

  function automatic logic [3:0] instr_imm(input logic [DEF_INSTR_WIDTH-1:0] instr);
    return instr[3:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_alu.sv
// cpu_alu -- combinational result/carry/write-strobe generation for one decoded opcode.
// Revision 1.0
`default_nettype none

module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            imm,
  input  logic                  carry_in,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry_out,
  output logic                  writes
);

  logic [DATA_WIDTH:0] sum;

  always_comb begin
    result    = '0;
    carry_out = carry_in;
    writes    = 1'b0;
    sum       = '0;
    case (opcode)
      OP_LDI: begin
        result = DATA_WIDTH'(imm);
        writes = 1'b1;
      end
      OP_ADD: begin
        sum       = {1'b0, a} + {1'b0, b};
        result    = sum[DATA_WIDTH-1:0];
        carry_out = sum[DATA_WIDTH];
        writes    = 1'b1;
      end
      // the extra MSB of the widened difference is the borrow (set when a < b)
      OP_SUB: begin
        sum       = {1'b0, a} - {1'b0, b};
        result    = sum[DATA_WIDTH-1:0];
        carry_out = sum[DATA_WIDTH];
        writes    = 1'b1;
      end
      OP_AND: begin
        result = a & b;
        writes = 1'b1;
      end
      OP_OR: begin
        result = a | b;
        writes = 1'b1;
      end
      OP_XOR: begin
        result = a ^ b;
        writes = 1'b1;
      end
      OP_INC: begin
        sum       = {1'b0, a} + {{DATA_WIDTH{1'b0}}, 1'b1};
        result    = sum[DATA_WIDTH-1:0];
        carry_out = sum[DATA_WIDTH];
        writes    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_control_unit.sv
// cpu_control_unit -- fetch/decode/execute sequencer owning PC, IR, carry and halt state.
// Revision 1.0
`default_nettype none

module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_valid,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic [DATA_WIDTH-1:0]  reg_a,
  input  logic [DATA_WIDTH-1:0]  reg_b,
  output logic                   write_enable,
  output logic [DATA_WIDTH-1:0]  write_data,
  output logic                   carry,
  output logic                   halted,
  output logic [PC_WIDTH-1:0]    pc
);

  state_t                  state;
  logic [INSTR_WIDTH-1:0]  ir;
  logic [PC_WIDTH-1:0]     next_pc;
  logic                    we_q;

  logic [3:0]              opcode;
  logic [PC_WIDTH-1:0]     imm_pc;
  logic [PC_WIDTH-1:0]     branch_pc;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic                    alu_carry;
  logic                    alu_writes;

  assign opcode    = instr_opcode(ir);
  assign imm_pc    = PC_WIDTH'(instr_imm(ir));
  assign imem_addr = pc;
  assign imem_req  = (state == ST_FETCH) && !reset;
  // a reset arriving during EXEC must cancel the strobe before register_file samples it
  assign write_enable = we_q && !reset;

  cpu_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .opcode   (opcode),
    .a        (reg_a),
    .b        (reg_b),
    .imm      (instr_imm(ir)),
    .carry_in (carry),
    .result   (alu_result),
    .carry_out(alu_carry),
    .writes   (alu_writes)
  );

  // branch decisions use reg_a and carry as seen in DECODE
  always_comb begin
    branch_pc = pc + PC_WIDTH'(1);
    case (opcode)
      OP_JMP:  branch_pc = imm_pc;
      OP_JZ:   if (reg_a == '0) branch_pc = imm_pc;
      OP_JC:   if (carry)       branch_pc = imm_pc;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_FETCH;
      pc         <= '0;
      ir         <= '0;
      next_pc    <= '0;
      carry      <= 1'b0;
      halted     <= 1'b0;
      we_q       <= 1'b0;
      write_data <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          we_q <= 1'b0;
          if (imem_valid) begin
            ir    <= imem_data;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          carry   <= alu_carry;
          we_q    <= alu_writes;
          next_pc <= branch_pc;
          if (alu_writes) write_data <= alu_result;
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          we_q <= 1'b0;
          pc   <= next_pc;
          if (opcode == OP_HALT) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            state  <= ST_FETCH;
          end
        end
        ST_HALT: begin
          we_q  <= 1'b0;
          state <= ST_HALT;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire
